// File: rtl/pipelined_mac_unit.sv
// rtl/pipelined_mac_unit.sv - three-stage pipelined multiply-accumulate unit with windowed result
//
// Purpose: multiplies operandA by operandB and sums AccCycles accepted products per window.
//          Each completed window sum is presented on AccResult with a one-cycle resultValid pulse.
//          The pulse appears three edges after the window's last sample is accepted.
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous active-high reset; discards everything, zeroes AccResult
//   clear        synchronous window abort; AccResult holds
//   newData      operand pair valid strobe, one sample per high cycle
//   operandA/B   multiplicand / multiplier
//   AccResult    last completed window sum (registered, holds between pulses)
//   resultValid  one-cycle pulse when AccResult updates
//   overflow     clamp occurred in the reported window (meaningful with resultValid)
// Configuration: define MAC_SATURATE_EN for saturating accumulation and a live overflow flag;
//                otherwise accumulation wraps and overflow is tied to 0.
module pipelined_mac_unit #(
    parameter int bitwidthA      = 8,
    parameter int bitwidthB      = 8,
    parameter int AccCycles      = 400,
    parameter int bitwidthAccRes = 25,
    parameter int SignedMode     = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      newData,
    input  logic [bitwidthA-1:0]      operandA,
    input  logic [bitwidthB-1:0]      operandB,
    output logic [bitwidthAccRes-1:0] AccResult,
    output logic                      resultValid,
    output logic                      overflow
);
    localparam int          PW       = bitwidthA + bitwidthB;
    localparam int          W        = bitwidthAccRes;
    localparam logic [15:0] LAST_IDX = 16'(AccCycles - 1);

    // Stage 1: operands
    logic [bitwidthA-1:0] a_q, a_d;
    logic [bitwidthB-1:0] b_q, b_d;
    logic                 v1_q, v1_d;
    // Stage 2: full-width product
    logic [PW-1:0]        prod_q, prod_d;
    logic                 v2_q, v2_d;
    // Stage 3: accumulator, window counter and closed-window capture
    logic [W-1:0]         acc_q, acc_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [W-1:0]         win_sum_q, win_sum_d;
    logic                 win_done_q, win_done_d;
    // Output registers
    logic [W-1:0]         acc_result_q, acc_result_d;
    logic                 result_valid_q, result_valid_d;

    logic [PW-1:0]        a_ext, b_ext;
    logic [W-1:0]         prod_ext, sum_wrap, sum_add;
    logic                 close;

    // Operands are widened to the product width first so a single unsigned
    // multiply, truncated to PW bits, yields the correct two's-complement product.
    always_comb begin
        a_ext = PW'(a_q);
        b_ext = PW'(b_q);
        if (SignedMode != 0) begin
            a_ext = ({PW{a_q[bitwidthA-1]}} << bitwidthA) | PW'(a_q);
            b_ext = ({PW{b_q[bitwidthB-1]}} << bitwidthB) | PW'(b_q);
        end
        prod_d = a_ext * b_ext;

        prod_ext = W'(prod_q);
        if (SignedMode != 0) begin
            prod_ext = ({W{prod_q[PW-1]}} << PW) | W'(prod_q);
        end
        sum_wrap = acc_q + prod_ext;
        close    = v2_q && (cnt_q == LAST_IDX);
    end

    always_comb begin
        a_d            = operandA;
        b_d            = operandB;
        v1_d           = newData;
        v2_d           = v1_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        win_sum_d      = win_sum_q;
        win_done_d     = 1'b0;
        if (close) begin
            // Last product of the window: capture the final sum, restart at zero
            // so a product arriving next cycle opens the next window cleanly.
            win_sum_d  = sum_add;
            win_done_d = 1'b1;
            acc_d      = '0;
            cnt_d      = '0;
        end else if (v2_q) begin
            acc_d      = sum_add;
            cnt_d      = cnt_q + 16'd1;
        end
        acc_result_d   = win_done_q ? win_sum_q : acc_result_q;
        result_valid_d = win_done_q;
        if (clear) begin
            v1_d           = 1'b0;
            v2_d           = 1'b0;
            acc_d          = '0;
            cnt_d          = '0;
            win_done_d     = 1'b0;
            result_valid_d = 1'b0;
            acc_result_d   = acc_result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q            <= '0;
            b_q            <= '0;
            v1_q           <= 1'b0;
            prod_q         <= '0;
            v2_q           <= 1'b0;
            acc_q          <= '0;
            cnt_q          <= '0;
            win_sum_q      <= '0;
            win_done_q     <= 1'b0;
            acc_result_q   <= '0;
            result_valid_q <= 1'b0;
        end else begin
            a_q            <= a_d;
            b_q            <= b_d;
            v1_q           <= v1_d;
            prod_q         <= prod_d;
            v2_q           <= v2_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            win_sum_q      <= win_sum_d;
            win_done_q     <= win_done_d;
            acc_result_q   <= acc_result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign AccResult   = acc_result_q;
    assign resultValid = result_valid_q;

`ifdef MAC_SATURATE_EN
    logic clamp;
    logic sat_q, sat_d;
    logic win_ovf_q, win_ovf_d;
    logic overflow_q, overflow_d;

    always_comb begin
        clamp   = 1'b0;
        sum_add = sum_wrap;
        if (SignedMode != 0) begin
            // Signed overflow: both addends share a sign the wrapped sum lost.
            if ((acc_q[W-1] == prod_ext[W-1]) && (sum_wrap[W-1] != acc_q[W-1])) begin
                clamp   = 1'b1;
                sum_add = acc_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end
        end else if (sum_wrap < acc_q) begin
            // Unsigned carry-out shows up as the wrapped sum dropping below acc.
            clamp   = 1'b1;
            sum_add = '1;
        end

        sat_d     = sat_q;
        win_ovf_d = 1'b0;
        if (close) begin
            win_ovf_d = sat_q | clamp;
            sat_d     = 1'b0;
        end else if (v2_q) begin
            sat_d     = sat_q | clamp;
        end
        overflow_d = win_done_q & win_ovf_q;
        if (clear) begin
            sat_d      = 1'b0;
            win_ovf_d  = 1'b0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_q      <= 1'b0;
            win_ovf_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            sat_q      <= sat_d;
            win_ovf_q  <= win_ovf_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign sum_add  = sum_wrap;
    assign overflow = 1'b0;
`endif

endmodule
